approx_add_err_monitor: RTL

- Streaming error-measurement block for approximate adders such as the 16-bit ripple-carry adders with 12 approximate LSBs.
- For each operand pair it takes the adder's approximate sum, forms the exact sum and the absolute error, and updates error statistics over a batch of N samples.
- At the end of the batch it computes the mean absolute error (MAE) with a sequential divider.
- Used in hardware-in-the-loop characterisation next to the adder under test.

---
 rtl/approx_add_err_monitor.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/approx_add_err_monitor.sv
// Streaming error monitor for approximate adders: compares an approximate sum against the exact sum,
// gathers error statistics over a batch of N samples and computes the mean absolute error by restoring division.
module approx_add_err_monitor #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 32,
    parameter int ACC_W = 49
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] IN1,
    input  logic [WIDTH-1:0] IN2,
    input  logic [WIDTH:0]   approx_sum,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
    output logic [WIDTH:0]   max_abs_err,
    output logic [ACC_W-1:0] sum_abs_err,
    output logic [ACC_W-1:0] mae
);

    localparam int DCW = $clog2(ACC_W);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        DIV,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] n_lat;

    logic             s1_valid;
    logic [WIDTH:0]   s1_exact;
    logic [WIDTH:0]   s1_approx;
    logic [WIDTH:0]   abs_err;

    logic             drain_cnt;
    logic [DCW-1:0]   div_cnt;
    logic [ACC_W-1:0] div_q;
    logic [ACC_W-1:0] div_q_next;
    logic [CNT_W-1:0] div_rem;
    logic [CNT_W-1:0] div_rem_next;
    logic [CNT_W:0]   rem_sh;
    logic             rem_ge;

    logic             hs;
    logic             last_hs;

    assign in_ready = (state == RUN) && (sample_count < n_lat);
    assign hs       = in_valid && in_ready;
    // sample_count < n_lat whenever hs is high, so the increment cannot wrap
    assign last_hs  = hs && ((sample_count + CNT_W'(1)) == n_lat);

    always_comb begin
        abs_err = '0;
        if (s1_exact >= s1_approx) begin
            abs_err = s1_exact - s1_approx;
        end else begin
            abs_err = s1_approx - s1_exact;
        end
    end

    // One restoring-division step: the remainder stays below N, so it fits in CNT_W bits after subtraction
    always_comb begin
        rem_sh       = {div_rem, div_q[ACC_W-1]};
        rem_ge       = (rem_sh >= {1'b0, n_lat});
        div_rem_next = rem_ge ? CNT_W'(rem_sh - {1'b0, n_lat}) : div_rem;
        if (!rem_ge) begin
            div_rem_next = rem_sh[CNT_W-1:0];
        end
        div_q_next   = {div_q[ACC_W-2:0], rem_ge};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_exact  <= '0;
            s1_approx <= '0;
        end else begin
            s1_valid <= hs;
            if (hs) begin
                s1_exact  <= {1'b0, IN1} + {1'b0, IN2};
                s1_approx <= approx_sum;
            end
        end
    end

    // Batch FSM; statistics live here too because an accepted start must clear them
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            n_lat        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            sample_count <= '0;
            err_count    <= '0;
            max_abs_err  <= '0;
            sum_abs_err  <= '0;
            mae          <= '0;
            drain_cnt    <= 1'b0;
            div_cnt      <= '0;
            div_q        <= '0;
            div_rem      <= '0;
        end else begin
            if (s1_valid) begin
                sum_abs_err <= sum_abs_err + ACC_W'(abs_err);
                if (abs_err != '0) begin
                    err_count <= err_count + CNT_W'(1);
                end
                if (abs_err > max_abs_err) begin
                    max_abs_err <= abs_err;
                end
            end
            if (hs) begin
                sample_count <= sample_count + CNT_W'(1);
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        n_lat        <= num_samples;
                        sample_count <= '0;
                        err_count    <= '0;
                        max_abs_err  <= '0;
                        sum_abs_err  <= '0;
                        mae          <= '0;
                        if (num_samples != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (last_hs) begin
                        state     <= DRAIN;
                        drain_cnt <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (drain_cnt) begin
                        state   <= DIV;
                        div_q   <= sum_abs_err;
                        div_rem <= '0;
                        div_cnt <= '0;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                DIV: begin
                    div_q   <= div_q_next;
                    div_rem <= div_rem_next;
                    div_cnt <= div_cnt + DCW'(1);
                    if (div_cnt == DCW'(ACC_W - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        mae   <= div_q_next;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
